// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared encodings for the multicycle RV32I control unit
//
// Purpose: state enum, opcode constants, ALUOp and ALUControl codes and
//          datapath mux-select constants used by multicycle_control and
//          alu_decoder.
// Ports:   none (package)
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_ILLEGAL
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   // ADD is 00 so an idle state naturally requests an add.
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b011;

   localparam logic       ADR_PC        = 1'b0;
   localparam logic       ADR_ALUOUT    = 1'b1;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC       = 2'b00;
   localparam logic [1:0] SRCA_OLDPC    = 2'b01;
   localparam logic [1:0] SRCA_RS1      = 2'b10;

   localparam logic [1:0] SRCB_RS2      = 2'b00;
   localparam logic [1:0] SRCB_IMM      = 2'b01;
   localparam logic [1:0] SRCB_FOUR     = 2'b10;

   localparam logic [1:0] IMM_I         = 2'b00;
   localparam logic [1:0] IMM_S         = 2'b01;
   localparam logic [1:0] IMM_B         = 2'b10;
   localparam logic [1:0] IMM_J         = 2'b11;

   // Only add/sub, or and and exist in the ALU; every other funct3 is illegal.
   function automatic logic funct3_supported(input logic [2:0] funct3);
      return (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control-unit to datapath signal bundle
//
// Purpose: groups the instruction fields and ALU flag going into the control
//          unit together with every control output going to the datapath.
// Modports:
//   master - control unit: reads op/funct3/funct7b5/zero, drives controls
//   slave  - datapath: drives op/funct3/funct7b5/zero, reads controls
interface multicycle_control_if;

   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic       RegWrite;
   logic [2:0] ALUControl;
   logic       illegal;

   modport master (
      input  op, funct3, funct7b5, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal
   );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - combinational ALUOp/funct to ALUControl decoder
//
// Purpose: maps the FSM's ALUOp request plus instruction fields to the
//          3-bit ALUControl consumed by the ALU.
// Ports:
//   aluop      in  2  ADD / SUB / FUNCT request from the FSM
//   funct3     in  3  instruction[14:12]
//   op5        in  1  instruction[5], distinguishes R-type from I-ALU
//   funct7b5   in  1  instruction[30]
//   alucontrol out 3  ALU operation select
module alu_decoder
   import multicycle_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALUC_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALUC_ADD;
         ALUOP_SUB: alucontrol = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // addi never subtracts: funct7b5 is an immediate bit there.
               3'b000:  alucontrol = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
               3'b110:  alucontrol = ALUC_OR;
               3'b111:  alucontrol = ALUC_AND;
               default: alucontrol = ALUC_ADD;
            endcase
         end
         default: alucontrol = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle RV32I core
//
// Purpose: sequences each instruction through fetch, decode, execute, memory
//          and writeback, driving all datapath enables and mux selects.
//          Optional performance counters are built when
//          MULTICYCLE_CONTROL_PERF_EN is defined.
// Ports:
//   clk      in      core clock
//   reset    in      synchronous, active-high; forces all outputs to 0
//   ctrl     master  op/funct3/funct7b5/zero in, datapath controls out
//   instret  out 32  retired-instruction count (PERF_EN only)
//   cycles   out 32  cycles out of reset (PERF_EN only)
module multicycle_control
   import multicycle_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   multicycle_control_if.master  ctrl
`ifdef MULTICYCLE_CONTROL_PERF_EN
   ,
   output logic [31:0]           instret,
   output logic [31:0]           cycles
`endif
);

   state_t     state;
   state_t     next_state;

   aluop_t     aluop;
   logic       pcupdate;
   logic       branch;
   logic       adrsrc;
   logic       memwrite;
   logic       irwrite;
   logic [1:0] resultsrc;
   logic [1:0] alusrca;
   logic [1:0] alusrcb;
   logic [1:0] immsrc;
   logic       regwrite;
   logic       illegal;
   logic [2:0] alucontrol;

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            case (ctrl.op)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE:     next_state = funct3_supported(ctrl.funct3) ? S_EXECR : S_ILLEGAL;
               OP_IALU:      next_state = funct3_supported(ctrl.funct3) ? S_EXECI : S_ILLEGAL;
               OP_BEQ:       next_state = S_BEQ;
               OP_JAL:       next_state = S_JAL;
               default:      next_state = S_ILLEGAL;
            endcase
         end
         S_MEMADR:  next_state = (ctrl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: next_state = S_MEMWB;
         S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
         default:   next_state = S_FETCH;
      endcase
   end

   always_comb begin
      aluop     = ALUOP_ADD;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      adrsrc    = ADR_PC;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      resultsrc = RES_ALUOUT;
      alusrca   = SRCA_PC;
      alusrcb   = SRCB_RS2;
      regwrite  = 1'b0;
      illegal   = 1'b0;
      case (state)
         S_FETCH: begin
            irwrite   = 1'b1;
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALURESULT;
            pcupdate  = 1'b1;
         end
         S_DECODE: begin
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
         end
         S_MEMADR: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
         end
         S_MEMREAD:  adrsrc = ADR_ALUOUT;
         S_MEMWRITE: begin
            adrsrc   = ADR_ALUOUT;
            memwrite = 1'b1;
         end
         S_MEMWB: begin
            resultsrc = RES_DATA;
            regwrite  = 1'b1;
         end
         S_EXECR: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_RS2;
            aluop   = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB:   regwrite = 1'b1;
         S_BEQ: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_RS2;
            aluop   = ALUOP_SUB;
            branch  = 1'b1;
         end
         S_JAL: begin
            alusrca  = SRCA_OLDPC;
            alusrcb  = SRCB_FOUR;
            pcupdate = 1'b1;
         end
         S_ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      immsrc = IMM_I;
      case (ctrl.op)
         OP_SW:   immsrc = IMM_S;
         OP_BEQ:  immsrc = IMM_B;
         OP_JAL:  immsrc = IMM_J;
         default: immsrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop      (aluop),
      .funct3     (ctrl.funct3),
      .op5        (ctrl.op[5]),
      .funct7b5   (ctrl.funct7b5),
      .alucontrol (alucontrol)
   );

   // Outputs are gated by reset so an aborted instruction cannot write
   // anything in the cycle reset is seen.
   assign ctrl.PCWrite    = ~reset & (pcupdate | (branch & ctrl.zero));
   assign ctrl.AdrSrc     = ~reset & adrsrc;
   assign ctrl.MemWrite   = ~reset & memwrite;
   assign ctrl.IRWrite    = ~reset & irwrite;
   assign ctrl.ResultSrc  = reset ? 2'b00 : resultsrc;
   assign ctrl.ALUSrcA    = reset ? 2'b00 : alusrca;
   assign ctrl.ALUSrcB    = reset ? 2'b00 : alusrcb;
   assign ctrl.ImmSrc     = reset ? 2'b00 : immsrc;
   assign ctrl.RegWrite   = ~reset & regwrite;
   assign ctrl.ALUControl = reset ? 3'b000 : alucontrol;
   assign ctrl.illegal    = ~reset & illegal;

`ifdef MULTICYCLE_CONTROL_PERF_EN
   // Every completing state goes to FETCH next, so being in one of them
   // outside reset means an instruction retires at this edge.
   logic retire;
   assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                   (state == S_ALUWB) || (state == S_BEQ);

   always_ff @(posedge clk) begin
      if (reset) begin
         instret <= 32'd0;
         cycles  <= 32'd0;
      end else begin
         cycles <= cycles + 32'd1;
         if (retire) instret <= instret + 32'd1;
      end
   end
`endif

endmodule
